// File: rtl/row_shared_mem_arbiter.sv
// row_shared_mem_arbiter: round-robin URAM arbiter for one row of cores with lock, tagged read return and emptied flag.
// Define ARB_TIMEOUT_EN to add a watchdog that forces release after MAX_HOLD_CYCLES granted cycles.
module row_shared_mem_arbiter #(
  parameter int NUM_CORES       = 8,
  parameter int ADDR_WIDTH      = 12,
  parameter int DATA_WIDTH      = 32,
  parameter int RD_LATENCY      = 2,
  parameter int MAX_HOLD_CYCLES = 256
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CORES-1:0]            i_core_req,
  input  logic [NUM_CORES-1:0]            i_core_locked,
  output logic [NUM_CORES-1:0]            o_core_grant,
  input  logic [NUM_CORES-1:0]            i_core_en,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] i_core_addr,
  input  logic [NUM_CORES*DATA_WIDTH-1:0] i_core_wr_data,
  input  logic [NUM_CORES-1:0]            i_core_wr_en,
  output logic                            o_uram_en,
  output logic [ADDR_WIDTH-1:0]           o_uram_addr,
  output logic [DATA_WIDTH-1:0]           o_uram_wr_data,
  output logic                            o_uram_wr_en,
  input  logic [DATA_WIDTH-1:0]           i_uram_rd_data,
  output logic [DATA_WIDTH-1:0]           o_core_rd_data,
  output logic [NUM_CORES-1:0]            o_core_rd_valid,
  output logic                            o_uram_emptied,
  output logic                            o_timeout
);
  localparam int IW = $clog2(NUM_CORES);
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
  state_t state, state_nxt;
  logic [IW-1:0] owner, owner_nxt, rr_ptr, rr_ptr_nxt, pick, idx, owner_inc;
  logic [NUM_CORES-1:0] req_ok, owner_oh;
  logic own, keep, force_rel, rd_issue;
  logic [RD_LATENCY-1:0] vld;
  logic [IW-1:0] tag [RD_LATENCY];

  if (NUM_CORES < 2 || RD_LATENCY < 1 || MAX_HOLD_CYCLES < 2) begin : g_bad_cfg
    $error("row_shared_mem_arbiter: unsupported parameter set");
  end

  assign own = state == GRANT;
  assign owner_oh = NUM_CORES'(1) << owner;
  assign owner_inc = (owner == IW'(NUM_CORES - 1)) ? '0 : owner + 1'b1;
  assign keep = i_core_req[owner] | i_core_locked[owner];
  assign rd_issue = own & i_core_en[owner] & ~i_core_wr_en[owner];

  assign o_core_grant = own ? owner_oh : '0;
  assign o_uram_en = own & i_core_en[owner];
  assign o_uram_wr_en = own & i_core_en[owner] & i_core_wr_en[owner];
  assign o_uram_addr = own ? i_core_addr[int'(owner)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign o_uram_wr_data = own ? i_core_wr_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign o_core_rd_valid = vld[RD_LATENCY-1] ? NUM_CORES'(1) << tag[RD_LATENCY-1] : '0;
  assign o_core_rd_data = vld[RD_LATENCY-1] ? i_uram_rd_data : '0;

  // Lowest offset from rr_ptr wins, so scan from the far end and let nearer hits overwrite.
  always_comb begin
    pick = '0;
    idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      idx = IW'((int'(rr_ptr) + i) % NUM_CORES);
      if (req_ok[idx]) pick = idx;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: if (|req_ok) begin
        state_nxt = GRANT;
        owner_nxt = pick;
      end
      GRANT: if (force_rel || !keep) begin
        state_nxt = RELEASE;
        rr_ptr_nxt = owner_inc;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      owner <= '0;
      rr_ptr <= '0;
      vld <= '0;
      o_uram_emptied <= 1'b1;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
      vld <= RD_LATENCY'({vld, rd_issue});
      o_uram_emptied <= state == IDLE && !(|i_core_req) && !(|vld);
    end
  end

  // Tags need no reset: they are only looked at alongside a set valid bit.
  always_ff @(posedge clk) begin
    tag[0] <= owner;
    for (int i = 1; i < RD_LATENCY; i++) tag[i] <= tag[i-1];
  end

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD_CYCLES);
  logic [HW-1:0] hold;
  logic [NUM_CORES-1:0] evicted;

  assign force_rel = hold == HW'(MAX_HOLD_CYCLES - 1);
  assign req_ok = i_core_req & ~evicted;

  // An evicted core stays masked until it lowers both req and locked.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold <= '0;
      evicted <= '0;
      o_timeout <= 1'b0;
    end else begin
      hold <= own ? hold + 1'b1 : '0;
      o_timeout <= own & force_rel;
      evicted <= (evicted & (i_core_req | i_core_locked)) | ((own & force_rel) ? owner_oh : '0);
    end
  end
`else
  assign force_rel = 1'b0;
  assign req_ok = i_core_req;
  assign o_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_row_shared_mem_arbiter.sv
// tb_row_shared_mem_arbiter: directed self-checking bench for row_shared_mem_arbiter with a small URAM model.
module tb_row_shared_mem_arbiter;
  localparam int N = 8, AW = 12, DW = 32, RL = 2;
  logic clk = 1'b0, reset = 1'b0;
  logic [N-1:0] req = '0, locked = '0, en = '0, wr_en = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] wr_data = '0;
  logic [N-1:0] grant, rd_valid;
  logic uram_en, uram_wr_en, emptied, timeout;
  logic [AW-1:0] uram_addr;
  logic [DW-1:0] uram_wr_data, uram_rd_data, rd_data;
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] pipe [RL];
  logic [N-1:0] exp_b [8];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  row_shared_mem_arbiter #(
    .NUM_CORES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RL), .MAX_HOLD_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset),
    .i_core_req(req), .i_core_locked(locked), .o_core_grant(grant),
    .i_core_en(en), .i_core_addr(addr), .i_core_wr_data(wr_data), .i_core_wr_en(wr_en),
    .o_uram_en(uram_en), .o_uram_addr(uram_addr), .o_uram_wr_data(uram_wr_data), .o_uram_wr_en(uram_wr_en),
    .i_uram_rd_data(uram_rd_data), .o_core_rd_data(rd_data), .o_core_rd_valid(rd_valid),
    .o_uram_emptied(emptied), .o_timeout(timeout)
  );

  always @(posedge clk) begin
    if (uram_en && uram_wr_en) mem[uram_addr] <= uram_wr_data;
    pipe[0] <= mem[uram_addr];
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign uram_rd_data = pipe[RL-1];

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    exp_b = '{8'h02, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h20, 8'h00};
    repeat (2) cyc();
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_uram_en", uram_en, 0);
    chk("rst_uram_wr_en", uram_wr_en, 0);
    chk("rst_uram_addr", uram_addr, 0);
    chk("rst_uram_wr_data", uram_wr_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_emptied", emptied, 1);
    chk("rst_timeout", timeout, 0);
    // single owner: core 3 requests for 4 cycles from reset release
    reset = 1'b1;
    req[3] = 1'b1;
    #1;
    chk("a_latency_grant", grant, 0);
    chk("a_latency_emptied", emptied, 1);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      if (i == 4) req[3] = 1'b0;
      #1;
      chk("a_grant", grant, 8'h08);
      chk("a_emptied_busy", emptied, 0);
    end
    cyc(); #1;
    chk("a_release_grant", grant, 0);
    chk("a_release_emptied", emptied, 0);
    cyc(); #1;
    chk("a_idle_emptied", emptied, 0);
    cyc(); #1;
    chk("a_emptied_back", emptied, 1);
    // round robin among cores 1, 2, 5 from rr_ptr 0
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    req = 8'b0010_0110;
    #1;
    chk("b_reset_grant", grant, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(); #1;
      chk("b_grant_seq", grant, exp_b[i]);
      req = req & ~exp_b[i];
    end
    // core 0 write then read, plus a read in its last granted cycle
    cyc();
    req[0] = 1'b1;
    #1;
    chk("c_pre_grant", grant, 0);
    cyc();
    en[0] = 1'b1;
    wr_en[0] = 1'b1;
    addr[0 +: AW] = 12'h010;
    wr_data[0 +: DW] = 32'hDEADBEEF;
    #1;
    chk("c_grant", grant, 8'h01);
    chk("c_wr_uram_en", uram_en, 1);
    chk("c_wr_uram_wr_en", uram_wr_en, 1);
    chk("c_wr_addr", uram_addr, 12'h010);
    chk("c_wr_data", uram_wr_data, 32'hDEADBEEF);
    cyc();
    wr_en[0] = 1'b0;
    #1;
    chk("c_rd_uram_en", uram_en, 1);
    chk("c_rd_uram_wr_en", uram_wr_en, 0);
    chk("c_rd_valid_early0", rd_valid, 0);
    cyc();
    en[0] = 1'b0;
    #1;
    chk("c_rd_valid_early1", rd_valid, 0);
    chk("c_idle_uram_en", uram_en, 0);
    cyc(); #1;
    chk("c_rd_valid", rd_valid, 8'h01);
    chk("c_rd_data", rd_data, 32'hDEADBEEF);
    cyc();
    req[0] = 1'b0;
    en[0] = 1'b1;
    #1;
    chk("c_last_grant", grant, 8'h01);
    chk("c_last_rd_valid", rd_valid, 0);
    cyc();
    en[0] = 1'b0;
    #1;
    chk("c_drop_grant", grant, 0);
    chk("c_drop_uram_en", uram_en, 0);
    cyc(); #1;
    chk("c_late_rd_valid", rd_valid, 8'h01);
    chk("c_late_rd_data", rd_data, 32'hDEADBEEF);
    chk("c_late_grant", grant, 0);
    cyc(); #1;
    chk("c_pending_emptied", emptied, 0);
    chk("c_after_rd_valid", rd_valid, 0);
    cyc(); #1;
    chk("c_emptied", emptied, 1);
    // non-owner core 4 strobes while core 2 owns
    cyc();
    req[2] = 1'b1;
    req[4] = 1'b1;
    en[4] = 1'b1;
    wr_en[4] = 1'b1;
    addr[4*AW +: AW] = 12'h0AA;
    wr_data[4*DW +: DW] = 32'h44444444;
    #1;
    chk("d_noowner_en", uram_en, 0);
    chk("d_noowner_wr_en", uram_wr_en, 0);
    chk("d_noowner_addr", uram_addr, 0);
    chk("d_noowner_data", uram_wr_data, 0);
    cyc();
    en[2] = 1'b1;
    wr_en[2] = 1'b1;
    addr[2*AW +: AW] = 12'h123;
    wr_data[2*DW +: DW] = 32'h22222222;
    #1;
    chk("d_grant", grant, 8'h04);
    chk("d_uram_en", uram_en, 1);
    chk("d_uram_wr_en", uram_wr_en, 1);
    chk("d_addr", uram_addr, 12'h123);
    chk("d_data", uram_wr_data, 32'h22222222);
    cyc();
    en[2] = 1'b0;
    req[2] = 1'b0;
    #1;
    chk("d_quiet_grant", grant, 8'h04);
    chk("d_quiet_en", uram_en, 0);
    chk("d_quiet_wr_en", uram_wr_en, 0);
    chk("d_quiet_addr", uram_addr, 12'h123);
    cyc(); #1;
    chk("d_release_grant", grant, 0);
    cyc(); #1;
    chk("d_idle_grant", grant, 0);
    // core 4 takes over and issues a read, then reset hits with it in flight
    cyc();
    wr_en[4] = 1'b0;
    #1;
    chk("e_grant", grant, 8'h10);
    chk("e_uram_en", uram_en, 1);
    chk("e_uram_wr_en", uram_wr_en, 0);
    chk("e_addr", uram_addr, 12'h0AA);
    cyc();
    reset = 1'b0;
    req = '0;
    en = '0;
    wr_en = '0;
    #1;
    chk("e_inflight_grant", grant, 8'h10);
    chk("e_inflight_rd_valid", rd_valid, 0);
    cyc();
    reset = 1'b1;
    #1;
    chk("e_reset_grant", grant, 0);
    chk("e_reset_rd_valid", rd_valid, 0);
    chk("e_reset_emptied", emptied, 1);
    chk("e_reset_uram_en", uram_en, 0);
    cyc(); #1;
    chk("e_stale_rd_valid", rd_valid, 0);
    chk("e_stale_rd_data", rd_data, 0);
`ifdef ARB_TIMEOUT_EN
    req[6] = 1'b1;
    locked[6] = 1'b1;
    req[7] = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      cyc(); #1;
      chk("t_hold_grant", grant, 8'h40);
      chk("t_hold_timeout", timeout, 0);
    end
    cyc(); #1;
    chk("t_evict_grant", grant, 0);
    chk("t_pulse", timeout, 1);
    cyc(); #1;
    chk("t_idle_grant", grant, 0);
    chk("t_pulse_end", timeout, 0);
    cyc(); #1;
    chk("t_next_grant", grant, 8'h80);
`else
    chk("timeout_off", timeout, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/row_shared_mem_arbiter.md
Name: row_shared_mem_arbiter

Overview:
- Parametrised row-level arbiter that multiplexes NUM_CORES core-side shared-memory ports onto one URAM port.
- Successor to the single-core grant gating of the shared-memory path: it adds round-robin request/grant with lock, a pipelined read-return path tagged to the owning core, and a row "emptied" indication.
- Sits between the per-core shared-memory interfaces of one row and the row's URAM.

Parameters:
- NUM_CORES, 8, number of requesting cores in the row (2..16).
- ADDR_WIDTH, 12, URAM word-address width.
- DATA_WIDTH, 32, URAM data width.
- RD_LATENCY, 2, URAM read latency in cycles (1..4).
- MAX_HOLD_CYCLES, 256, watchdog limit; used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- i_core_req  in  NUM_CORES  per-core request for URAM ownership.
- i_core_locked  in  NUM_CORES  per-core lock; holds ownership across multiple accesses.
- o_core_grant  out  NUM_CORES  one-hot grant.
- i_core_en  in  NUM_CORES  per-core access strobe, valid only when granted.
- i_core_addr  in  NUM_CORES*ADDR_WIDTH  packed addresses; core k uses slice [k*ADDR_WIDTH +: ADDR_WIDTH].
- i_core_wr_data  in  NUM_CORES*DATA_WIDTH  packed write data.
- i_core_wr_en  in  NUM_CORES  word write enable.
- o_uram_en  out  1  URAM enable.
- o_uram_addr  out  ADDR_WIDTH  URAM address.
- o_uram_wr_data  out  DATA_WIDTH  URAM write data.
- o_uram_wr_en  out  1  URAM write enable.
- i_uram_rd_data  in  DATA_WIDTH  URAM read data, RD_LATENCY cycles after a read enable.
- o_core_rd_data  out  DATA_WIDTH  read data broadcast to all cores.
- o_core_rd_valid  out  NUM_CORES  one-hot read-return strobe.
- o_uram_emptied  out  1  no owner, no requests, no reads in flight.
- o_timeout  out  1  one-cycle pulse on forced release (ARB_TIMEOUT_EN only; tied 0 otherwise).

Behaviour:
- Reset (reset==0 at a clk edge):
  - FSM to IDLE, rr_ptr=0, read pipeline cleared.
  - Outputs after reset: all outputs 0 except o_uram_emptied=1.
  - Reset mid-transfer drops the grant and discards in-flight reads; no rd_valid issues for them.
- FSM states:
  - IDLE: if any i_core_req, select the first requester at or after rr_ptr (wrapping modulo NUM_CORES). Register the owner and go to GRANT. o_core_grant rises the cycle after the request is seen, so request-to-grant latency is 1 cycle.
  - GRANT:
    - The owner's en/addr/wr_data/wr_en pass combinationally to the URAM port.
    - o_uram_wr_en = i_core_en[owner] & i_core_wr_en[owner].
    - Non-owner strobes are ignored; the URAM port is 0 when no owner.
    - Stay while i_core_req[owner] | i_core_locked[owner].
    - When both are low, go to RELEASE, drop the grant that cycle, and set rr_ptr = owner+1 (mod NUM_CORES).
  - RELEASE: one dead cycle with no grant, guaranteeing a 1-cycle gap between owners; then go to IDLE.
    - Best case, back-to-back owners see grant low for 2 cycles.
- Read return:
  - A read (en & ~wr_en) pushes a valid bit plus owner index into an RD_LATENCY-deep shift pipeline.
  - At the output, o_core_rd_valid[tag]=1 with o_core_rd_data=i_uram_rd_data.
  - Reads issued in the last granted cycle still return after the grant drops.
- o_uram_emptied: registered; 1 when state==IDLE, no i_core_req bits set, and the read pipeline is empty.
- Simultaneous events:
  - Requests arriving during GRANT/RELEASE wait.
  - A requester that drops req before being granted is never granted.
  - Starvation-free: every continuously requesting core is granted within NUM_CORES ownerships.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - A hold counter clears on entering GRANT and increments each GRANT cycle.
  - On reaching MAX_HOLD_CYCLES-1, the FSM is forced to RELEASE regardless of req/locked.
  - rr_ptr advances and o_timeout pulses 1 cycle.
  - The evicted core must drop req/locked before it can be re-granted (re-arm on low).
- When undefined: no counter, o_timeout constant 0, ownership is unbounded.

Test Plan:
- Core 3 req=1 from reset release, locked=0; drops req after 4 cycles -> grant[3] high 1 cycle after req, for 4 cycles; emptied=0 during, back to 1 two cycles after release.
- Cores 1, 2, 5 request simultaneously with rr_ptr=0 -> grants in order 1, 2, 5, each separated by ≥1 grant-free cycle.
- Core 0 granted, writes 0xDEADBEEF at addr 0x010, then reads 0x010 with RD_LATENCY=2 -> wr_en pulse on URAM port; rd_valid[0]=1 exactly 2 cycles after the read with data 0xDEADBEEF.
- Non-owner core 4 drives en=1, wr_en=1 while core 2 owns -> URAM port carries only core 2's values; no write from core 4.
- Reset asserted low during a read in flight -> next cycle grant=0, rd_valid=0, emptied=1; the stale read is never reported.
- ARB_TIMEOUT_EN, MAX_HOLD_CYCLES=16, core 6 holds locked=1 indefinitely with core 7 requesting -> grant[6] falls after 16 cycles, o_timeout pulses, core 7 granted next.
